// File: rtl/m_mem_arb.sv
// rtl/m_mem_arb.sv - fetch/data arbiter onto a single memory port with starvation guard and read timeout
// Data has priority; fetch is forced through after STARVE consecutive data grants while it waits.
module m_mem_arb #(
    parameter int STARVE = 4,
    parameter int TMO    = 16
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_if_req,
    input  logic [31:0] w_if_addr,
    output logic        w_if_gnt,
    output logic        w_if_rvalid,
    output logic [31:0] w_if_rdata,
    input  logic        w_d_req,
    input  logic        w_d_we,
    input  logic [31:0] w_d_addr,
    input  logic [31:0] w_d_wdata,
    output logic        w_d_gnt,
    output logic        w_d_rvalid,
    output logic [31:0] w_d_rdata,
    output logic        w_m_en,
    output logic        w_m_we,
    output logic [31:0] w_m_addr,
    output logic [31:0] w_m_wdata,
    input  logic [31:0] w_m_rdata,
    input  logic        w_m_rvalid,
    output logic        w_err
);
    localparam int SW = $clog2(STARVE + 1);
    localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          err_nxt;
    logic          fetch_owed;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            w_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
            w_err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        wait_nxt    = wait_cnt;
        err_nxt     = w_err;
        w_if_gnt    = 1'b0;
        w_d_gnt     = 1'b0;
        w_if_rvalid = 1'b0;
        w_d_rvalid  = 1'b0;
        w_if_rdata  = '0;
        w_d_rdata   = '0;
        w_m_en      = 1'b0;
        w_m_we      = 1'b0;
        w_m_addr    = '0;
        w_m_wdata   = '0;
        fetch_owed  = w_if_req && (starve_cnt == SW'(STARVE));

        case (state)
            IDLE: begin
                if (w_d_req && !fetch_owed) begin
                    w_d_gnt   = 1'b1;
                    w_m_en    = 1'b1;
                    w_m_we    = w_d_we;
                    w_m_addr  = w_d_addr;
                    w_m_wdata = w_d_wdata;
                    // Writes retire in the grant cycle, so only reads leave IDLE
                    if (!w_d_we) begin
                        state_nxt = WAIT_D;
                        wait_nxt  = '0;
                    end
                end else if (w_if_req) begin
                    w_if_gnt  = 1'b1;
                    w_m_en    = 1'b1;
                    w_m_addr  = w_if_addr;
                    state_nxt = WAIT_IF;
                    wait_nxt  = '0;
                end
            end
            WAIT_IF, WAIT_D: begin
                if (w_m_rvalid) begin
                    if (state == WAIT_IF) begin
                        w_if_rvalid = 1'b1;
                        w_if_rdata  = w_m_rdata;
                    end else begin
                        w_d_rvalid = 1'b1;
                        w_d_rdata  = w_m_rdata;
                    end
                    state_nxt = IDLE;
                end else if (wait_cnt == WW'(TMO - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!w_if_req || w_if_gnt) begin
            starve_nxt = '0;
        end else if (w_d_gnt && (starve_cnt != SW'(STARVE))) begin
            starve_nxt = starve_cnt + 1'b1;
        end

        // Keep every strobe quiet while reset is held, even though IDLE would otherwise grant
        if (w_rst) begin
            w_if_gnt    = 1'b0;
            w_d_gnt     = 1'b0;
            w_if_rvalid = 1'b0;
            w_d_rvalid  = 1'b0;
            w_if_rdata  = '0;
            w_d_rdata   = '0;
            w_m_en      = 1'b0;
            w_m_we      = 1'b0;
            w_m_addr    = '0;
            w_m_wdata   = '0;
        end
    end
endmodule

// File: tb/tb_m_mem_arb.sv
// tb/tb_m_mem_arb.sv - scoreboard bench for m_mem_arb against a rule-level arbiter model
// Directed scenarios first, then randomized requesters, memory latency, stray responses and resets.
module tb_m_mem_arb;
    localparam int STARVE = 4;
    localparam int TMO    = 16;
    localparam int S_IDLE = 0;
    localparam int S_IF   = 1;
    localparam int S_D    = 2;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_if_req = 1'b0;
    logic [31:0] w_if_addr = '0;
    logic        w_if_gnt, w_if_rvalid;
    logic [31:0] w_if_rdata;
    logic        w_d_req = 1'b0;
    logic        w_d_we = 1'b0;
    logic [31:0] w_d_addr = '0;
    logic [31:0] w_d_wdata = '0;
    logic        w_d_gnt, w_d_rvalid;
    logic [31:0] w_d_rdata;
    logic        w_m_en, w_m_we;
    logic [31:0] w_m_addr, w_m_wdata;
    logic [31:0] w_m_rdata = '0;
    logic        w_m_rvalid = 1'b0;
    logic        w_err;

    m_mem_arb #(.STARVE(STARVE), .TMO(TMO)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_if_req(w_if_req), .w_if_addr(w_if_addr), .w_if_gnt(w_if_gnt),
        .w_if_rvalid(w_if_rvalid), .w_if_rdata(w_if_rdata),
        .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
        .w_d_gnt(w_d_gnt), .w_d_rvalid(w_d_rvalid), .w_d_rdata(w_d_rdata),
        .w_m_en(w_m_en), .w_m_we(w_m_we), .w_m_addr(w_m_addr), .w_m_wdata(w_m_wdata),
        .w_m_rdata(w_m_rdata), .w_m_rvalid(w_m_rvalid), .w_err(w_err)
    );

    always #5 w_clk = ~w_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the memory port, cycles waited, consecutive data grants, sticky error
    int          st = S_IDLE;
    int          wcnt = 0;
    int          starve = 0;
    int          lat = 0;
    bit          err = 1'b0;
    logic [31:0] resp_data = '0;

    bit if_pend = 1'b0, d_pend = 1'b0, rand_mode = 1'b0, force_stray = 1'b0;
    bit measure = 1'b0, seen_if = 1'b0;
    int force_lat = 0, d_burst = 0, d_before_if = 0;

    logic [32:0] sb_q[$];
    logic [32:0] sb_ent;

    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_m_en, e_m_we;
    logic [31:0] e_if_rd, e_d_rd, e_m_addr, e_m_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'h13 : ({a[15:0], a[31:16]} ^ 32'hC3A5_5A3C);
    endfunction

    function automatic int pick_lat();
        int r;
        if (force_lat != 0) return force_lat;
        r = int'($urandom_range(0, 15));
        if (r == 0) return TMO + 3;
        if (r == 1) return TMO;
        return int'($urandom_range(1, 5));
    endfunction

    task automatic drive_requests();
        if (rand_mode) begin
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend   = 1'b1;
                w_if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend    = 1'b1;
                w_d_we    = ($urandom_range(0, 4) < 3);
                w_d_addr  = $urandom() & 32'hFFFF_FFFC;
                w_d_wdata = $urandom();
            end
        end
        if (!d_pend && d_burst > 0) begin
            d_pend    = 1'b1;
            d_burst--;
            w_d_we    = 1'b1;
            w_d_addr  = 32'h300 + 32'(d_burst * 4);
            w_d_wdata = $urandom();
        end
        w_if_req = if_pend;
        w_d_req  = d_pend;
    endtask

    task automatic drive_memory();
        w_m_rvalid = 1'b0;
        w_m_rdata  = $urandom();
        if (force_stray) begin
            w_m_rvalid = 1'b1;
            w_m_rdata  = 32'hDEAD_BEEF;
        end else if (st != S_IDLE) begin
            if (wcnt == lat - 1) begin
                w_m_rvalid = 1'b1;
                w_m_rdata  = resp_data;
            end
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            w_m_rvalid = 1'b1;
            w_m_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic predict();
        bit fetch_owed;
        {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_m_en, e_m_we} = '0;
        e_if_rd = '0; e_d_rd = '0; e_m_addr = '0; e_m_wdata = '0;
        if (w_rst) return;
        if (st == S_IDLE) begin
            fetch_owed = w_if_req && (starve == STARVE);
            if (w_d_req && !fetch_owed) e_d_gnt = 1'b1;
            else if (w_if_req)          e_if_gnt = 1'b1;
            e_m_en = e_if_gnt | e_d_gnt;
            if (e_d_gnt) begin
                e_m_we    = w_d_we;
                e_m_addr  = w_d_addr;
                e_m_wdata = w_d_wdata;
            end
            if (e_if_gnt) e_m_addr = w_if_addr;
        end else if (w_m_rvalid) begin
            if (st == S_IF) begin e_if_rv = 1'b1; e_if_rd = w_m_rdata; end
            else            begin e_d_rv  = 1'b1; e_d_rd  = w_m_rdata; end
        end
    endtask

    task automatic compare();
        check("if_gnt",    32'(w_if_gnt),    32'(e_if_gnt));
        check("d_gnt",     32'(w_d_gnt),     32'(e_d_gnt));
        check("if_rvalid", 32'(w_if_rvalid), 32'(e_if_rv));
        check("d_rvalid",  32'(w_d_rvalid),  32'(e_d_rv));
        check("if_rdata",  w_if_rdata,       e_if_rd);
        check("d_rdata",   w_d_rdata,        e_d_rd);
        check("m_en",      32'(w_m_en),      32'(e_m_en));
        check("m_we",      32'(w_m_we),      32'(e_m_we));
        check("m_addr",    w_m_addr,         e_m_addr);
        check("m_wdata",   w_m_wdata,        e_m_wdata);
        check("err",       32'(w_err),       32'(w_rst ? 1'b0 : err));
        if (measure) begin
            if (w_if_gnt) seen_if = 1'b1;
            else if (!seen_if && w_d_gnt) d_before_if++;
        end
    endtask

    task automatic advance();
        if (w_rst) begin
            st = S_IDLE; wcnt = 0; starve = 0; err = 1'b0;
            return;
        end
        if (!w_if_req || e_if_gnt) starve = 0;
        else if (e_d_gnt && starve < STARVE) starve++;
        if (st == S_IDLE) begin
            if (e_if_gnt || (e_d_gnt && !w_d_we)) begin
                st        = e_if_gnt ? S_IF : S_D;
                wcnt      = 0;
                resp_data = mem_f(e_if_gnt ? w_if_addr : w_d_addr);
                lat       = pick_lat();
            end
        end else if (w_m_rvalid) begin
            st = S_IDLE;
        end else if (wcnt == TMO - 1) begin
            err = 1'b1;
            st  = S_IDLE;
        end else begin
            wcnt++;
        end
        if (e_if_gnt) if_pend = 1'b0;
        if (e_d_gnt)  d_pend  = 1'b0;
    endtask

    // One clock: drive after the edge, check at the falling edge, update the model at the next edge
    task automatic step();
        drive_requests();
        drive_memory();
        predict();
        if (e_if_rv) sb_q.push_back({1'b0, resp_data});
        if (e_d_rv)  sb_q.push_back({1'b1, resp_data});
        @(negedge w_clk);
        compare();
        @(posedge w_clk);
        advance();
        #1;
    endtask

    always @(negedge w_clk) begin
        if (!w_rst && (w_if_rvalid || w_d_rvalid)) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: rvalid if=%b d=%b with no response expected at %0t",
                         w_if_rvalid, w_d_rvalid, $time);
            end else begin
                sb_ent = sb_q.pop_front();
                check("sb_who", 32'(w_d_rvalid), 32'(sb_ent[32]));
                check("sb_rdata", w_d_rvalid ? w_d_rdata : w_if_rdata, sb_ent[31:0]);
            end
        end
    end

    initial begin
        @(posedge w_clk);
        #1;
        repeat (2) step();
        w_rst = 1'b0;

        if_pend = 1'b1; w_if_addr = 32'h100; force_lat = 2;
        repeat (5) step();

        if_pend = 1'b1; w_if_addr = 32'h0;
        d_pend = 1'b1; w_d_we = 1'b0; w_d_addr = 32'h40; w_d_wdata = '0;
        repeat (10) step();

        if_pend = 1'b1; w_if_addr = 32'h200; d_burst = 6;
        measure = 1'b1; seen_if = 1'b0; d_before_if = 0;
        repeat (16) step();
        measure = 1'b0;
        check("starve_writes_before_fetch", 32'(d_before_if), 32'd4);

        d_pend = 1'b1; w_d_we = 1'b0; w_d_addr = 32'h80; force_lat = 1000;
        step();
        repeat (TMO - 1) step();
        check("tmo_err_not_yet", 32'(w_err), 32'd0);
        step();
        check("tmo_err_set", 32'(w_err), 32'd1);
        if_pend = 1'b1; w_if_addr = 32'h180; force_lat = 3;
        repeat (6) step();

        if_pend = 1'b1; w_if_addr = 32'h1C0; force_lat = 4;
        repeat (2) step();
        w_rst = 1'b1;
        step();
        w_rst = 1'b0; force_stray = 1'b1;
        step();
        force_stray = 1'b0;
        check("rst_clears_err", 32'(w_err), 32'd0);
        repeat (3) step();

        force_stray = 1'b1;
        step();
        force_stray = 1'b0;
        step();

        force_lat = 0; rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            w_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        w_rst = 1'b0; rand_mode = 1'b0;
        for (int i = 0; i < 200 && (st != S_IDLE || if_pend || d_pend); i++) step();
        step();
        check("drain_idle", 32'(st), 32'(S_IDLE));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
